axi_lite_read_master: RTL
=========================

// Module: axi_lite_read_master
// PURPOSE
//  Parametrised, synthesisable AXI4-Lite read master: walks COUNT addresses from BASE by STRIDE.
//  Keeps up to MAX_OUTST reads in flight and streams returned data out on a valid/ready port.
//  Sits between a host/sequencer and the MAC_TO_AXI_BUFFER S_AXI read channels.
//  Replaces fixed single-read stimulus with pipelined, back-pressured reads plus response checking.
// PARAMETERS
//  ADDR_W     32  AXI address width
//  DATA_W     32  AXI data width (32 or 64)
//  CNT_W      16  width of transfer count/index
//  MAX_OUTST   4  max AR accepted without matching R (1..15)
// PORTS
//  ACLK           in   1       single clock, all logic on posedge
//  ARESETN        in   1       asynchronous active-low reset
//  start_i        in   1       pulse; accepted only in IDLE
//  base_addr_i    in   ADDR_W  first read address, sampled on accepted start
//  stride_i       in   ADDR_W  address increment, sampled on accepted start
//  count_i        in   CNT_W   number of reads, sampled on accepted start
//  busy_o         out  1       high from accepted start until done_o cycle inclusive
//  done_o         out  1       one-cycle pulse: all COUNT responses accepted
//  err_cnt_o      out  CNT_W   count of RRESP!=OKAY since last start, saturating
//  rd_data_o      out  DATA_W  = S RDATA (combinational pass-through)
//  rd_resp_o      out  2       = RRESP
//  rd_idx_o       out  CNT_W   index (0..COUNT-1) of current rd_data_o beat
//  rd_data_v_o    out  1       = M_AXI_RVALID & (outst!=0)
//  rd_data_r_i    in   1       downstream ready
//  M_AXI_ARADDR   out  ADDR_W  read address
//  M_AXI_ARPROT   out  3       constant 3'b000
//  M_AXI_ARVALID  out  1       read address valid
//  M_AXI_ARREADY  in   1       slave address ready
//  M_AXI_RDATA    in   DATA_W  read data
//  M_AXI_RRESP    in   2       read response
//  M_AXI_RVALID   in   1       read data valid
//  M_AXI_RREADY   out  1       = rd_data_r_i & (outst!=0)
// BEHAVIOUR
//  Reset (async assert, sync deassert): state IDLE, ARVALID=0, ARADDR=0, busy/done=0, err_cnt=0,
//   issued=received=outst=0. Reset mid-transfer abandons in-flight reads; none reissued.
//  FSM IDLE->ISSUE on start_i & count_i!=0; IDLE->DONE on start_i & count_i==0 (no AXI traffic).
//   ISSUE->DRAIN when issued==COUNT; DRAIN->DONE when received==COUNT; DONE->IDLE after 1 cycle.
//   start_i outside IDLE ignored. err_cnt cleared on accepted start.
//  AR: ARVALID rises the cycle after start is accepted, ARADDR=BASE.
//   ARVALID high in ISSUE while issued<COUNT and outst<MAX_OUTST.
//   Once high, ARVALID/ARADDR hold until ARREADY; never retracted, even if outst limit reached.
//   On AR handshake ARADDR += STRIDE (mod 2^ADDR_W, wrap silent); issued++.
//   ARVALID does not depend combinationally on ARREADY.
//  R: handshake = RVALID & RREADY -> received++, rd_idx++.
//   RRESP!=2'b00 -> err_cnt++ (saturate at all-ones); data still forwarded.
//   RREADY low when outst==0; stray RVALID then not accepted.
//  outst: +1 on AR handshake, -1 on R handshake, unchanged when both occur in the same cycle.
//   Never exceeds MAX_OUTST.
//  done_o: the cycle after the last R handshake (state DONE); busy_o falls one cycle later.
//  Min latency start->first data: 2 cycles with zero-wait slave; back-to-back 1 read/cycle sustained.
// STRUCTURE
//  Shared package axi_lite_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR, rm_state_t enum {IDLE,ISSUE,DRAIN,DONE}.
//  One sub-module axi_lite_outst_tracker: up/down counter for outst with full/empty flags.
//  Remaining logic (FSM, AR regs, index/err counters) lives in the top module.
// TESTING
//  Zero-wait slave, base=0x100, stride=4, count=8 -> ARADDR 0x100..0x11C, 8 beats, rd_idx 0..7,
//   done_o 1 pulse, err_cnt=0.
//  ARREADY low 3 cycles on 2nd AR -> ARVALID/ARADDR=0x104 stable all 3 cycles, no retraction.
//  rd_data_r_i=0, count=10, MAX_OUTST=4 -> exactly 4 AR accepted, ARVALID then held.
//   Release -> remaining 6 issued, 10 beats total.
//  Slave returns SLVERR on beats 2,5 -> err_cnt_o=2 at done; restart clears to 0.
//  count=0 -> no ARVALID, done_o pulse 1 cycle after start; start during busy ignored.
//  base=0xFFFF_FFF8, stride=8, count=3 -> ARADDR 0xFFFF_FFF8,0x0,0x8.
//   ARESETN low mid-burst -> all outputs reset immediately.

Source files
------------

// File: rtl/axi_lite_read_master_pkg.sv
// axi_lite_pkg: shared AXI4-Lite response codes and read-master FSM state type.
//   RESP_*      2-bit RRESP encodings
//   rm_state_t  IDLE -> ISSUE -> DRAIN -> DONE -> IDLE
package axi_lite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} rm_state_t;
endpackage

// File: rtl/axi_lite_read_master_if.sv
// axi_lite_read_master_if: AXI4-Lite read address and read data channels.
//   araddr/arprot/arvalid/arready  AR channel
//   rdata/rresp/rvalid/rready      R channel
//   master modport drives AR payload and rready; slave modport drives the rest.
interface axi_lite_read_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    modport master (output araddr, arprot, arvalid, rready, input arready, rdata, rresp, rvalid);
    modport slave  (input araddr, arprot, arvalid, rready, output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/axi_lite_read_master_outst_tracker.sv
// axi_lite_outst_tracker: up/down count of reads accepted on AR but not yet answered on R.
//   clk, rst_n  clock, asynchronous active-low reset
//   inc, dec    AR handshake, R handshake (both at once leaves the count unchanged)
//   cnt         current number of reads in flight
//   full, empty cnt == MAX_OUTST, cnt == 0
module axi_lite_outst_tracker #(
    parameter int MAX_OUTST = 4,
    parameter int W         = $clog2(MAX_OUTST + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         full,
    output logic         empty
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (inc && !dec) cnt <= cnt + W'(1);
        else if (dec && !inc) cnt <= cnt - W'(1);
    end
    assign full  = cnt == W'(MAX_OUTST);
    assign empty = cnt == '0;
endmodule

// File: rtl/axi_lite_read_master.sv
// axi_lite_read_master: reads COUNT words from BASE by STRIDE with up to MAX_OUTST in flight.
//   ACLK, ARESETN                     clock, asynchronous active-low reset
//   start_i, base_addr_i, stride_i,
//   count_i                           job request, sampled when start_i is seen in IDLE
//   busy_o, done_o, err_cnt_o         job status; err_cnt_o counts non-OKAY responses (saturating)
//   rd_data_o, rd_resp_o, rd_idx_o,
//   rd_data_v_o, rd_data_r_i          returned beats streamed to the host with valid/ready
//   m_axi                             AXI4-Lite AR/R channels (master side)
module axi_lite_read_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic [ADDR_W-1:0]   stride_i,
    input  logic [CNT_W-1:0]    count_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [CNT_W-1:0]    err_cnt_o,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic [1:0]          rd_resp_o,
    output logic [CNT_W-1:0]    rd_idx_o,
    output logic                rd_data_v_o,
    input  logic                rd_data_r_i,
    axi_lite_read_master_if.master m_axi
);
    localparam int OW = $clog2(MAX_OUTST + 1);
    rm_state_t         state, state_nxt;
    logic [CNT_W-1:0]  count_r, issued, received, err_cnt;
    logic [ADDR_W-1:0] stride_r, araddr;
    logic [OW-1:0]     outst;
    logic              full, empty, start_ok, ar_hs, r_hs;

    axi_lite_outst_tracker #(.MAX_OUTST(MAX_OUTST), .W(OW)) u_outst (
        .clk(ACLK), .rst_n(ARESETN), .inc(ar_hs), .dec(r_hs),
        .cnt(outst), .full(full), .empty(empty)
    );

    assign start_ok = start_i && state == IDLE;
    // Derived from registered state only: once raised it can only fall through a handshake,
    // because outst cannot grow without one.
    assign m_axi.arvalid = state == ISSUE && issued != count_r && !full;
    assign m_axi.araddr  = araddr;
    assign m_axi.arprot  = 3'b000;
    // Nothing in flight means any RVALID is stray and must not be consumed.
    assign m_axi.rready  = rd_data_r_i && !empty;
    assign ar_hs         = m_axi.arvalid && m_axi.arready;
    assign r_hs          = m_axi.rvalid && m_axi.rready;
    assign rd_data_o     = m_axi.rdata;
    assign rd_resp_o     = m_axi.rresp;
    assign rd_idx_o      = received;
    assign rd_data_v_o   = m_axi.rvalid && !empty;
    assign busy_o        = state != IDLE;
    assign done_o        = state == DONE;
    assign err_cnt_o     = err_cnt;

    // Transitions look at the handshake about to complete so DONE follows the last beat directly.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_i) state_nxt = count_i == '0 ? DONE : ISSUE;
            ISSUE:   if (ar_hs && issued + 1'b1 == count_r) state_nxt = DRAIN;
            DRAIN:   if (r_hs && received + 1'b1 == count_r) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            count_r  <= '0;
            stride_r <= '0;
            araddr   <= '0;
            issued   <= '0;
            received <= '0;
            err_cnt  <= '0;
        end else if (start_ok) begin
            count_r  <= count_i;
            stride_r <= stride_i;
            araddr   <= base_addr_i;
            issued   <= '0;
            received <= '0;
            err_cnt  <= '0;
        end else begin
            if (ar_hs) begin
                araddr <= araddr + stride_r;
                issued <= issued + 1'b1;
            end
            if (r_hs) begin
                received <= received + 1'b1;
                if (m_axi.rresp != RESP_OKAY && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
        end
    end
endmodule
